// File: rtl/imem_line_responder_pkg.sv
// Shared definitions for the instruction-memory line responder: default widths, FSM states,
// and the line-offset width helper.
package imem_line_responder_pkg;

  localparam int IMEM_WORD_WIDTH = 32;
  localparam int IMEM_LINE_WIDTH = 128;
  localparam int IMEM_LATENCY    = 5;

  typedef enum logic [1:0] {
    IMEM_S_IDLE = 2'd0,
    IMEM_S_WAIT = 2'd1,
    IMEM_S_RESP = 2'd2,
    IMEM_S_DONE = 2'd3
  } imem_state_e;

  // Byte-offset bits inside one cache line; these are zeroed when a request is latched.
  function automatic int line_off_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/imem_line_responder_word_array.sv
// Word storage for the instruction image: one load write port and LINE_WORDS combinational
// read ports that return the word being written in the same cycle (write-first bypass).
module imem_line_responder_word_array
  import imem_line_responder_pkg::*;
#(
  parameter  int MEM_WORDS  = 4096,
  parameter  int LINE_WORDS = 4,
  localparam int AW         = $clog2(MEM_WORDS)
) (
  input  logic                                  clk,
  input  logic                                  i_we,
  input  logic [AW-1:0]                         i_waddr,
  input  logic [IMEM_WORD_WIDTH-1:0]            i_wdata,
  input  logic [AW-1:0]                         i_rbase,
  output logic [LINE_WORDS*IMEM_WORD_WIDTH-1:0] o_line
);

  logic [IMEM_WORD_WIDTH-1:0] r_mem [MEM_WORDS];

  // NOTE: storage is deliberately not reset; the image survives reset and is written by the load port.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_rd
    logic [AW-1:0] w_idx;
    // Index arithmetic wraps at MEM_WORDS, so a line straddling the top continues at word 0.
    assign w_idx = i_rbase + AW'(k);
    assign o_line[k*IMEM_WORD_WIDTH +: IMEM_WORD_WIDTH] =
      (i_we && (i_waddr == w_idx)) ? i_wdata : r_mem[w_idx];
  end

endmodule

// File: rtl/imem_line_responder.sv
// Instruction-cache refill responder: latches a miss, waits LATENCY cycles, returns one line.
// Optional IMEM_ADDR_CHECK_EN adds resp_err and rejects out-of-range requests and loads.
module imem_line_responder
  import imem_line_responder_pkg::*;
#(
  parameter int LINE_WIDTH = IMEM_LINE_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 4096,
  parameter int LATENCY    = IMEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_to_mem,
  input  logic [ADDR_WIDTH-1:0] req_to_mem_addr,
  output logic [LINE_WIDTH-1:0] in_data,
  output logic                  in_data_ready,
  output logic                  busy,
`ifdef IMEM_ADDR_CHECK_EN
  output logic                  resp_err,
`endif
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int LINE_WORDS = LINE_WIDTH / IMEM_WORD_WIDTH;
  localparam int LOFF       = line_off_bits(LINE_WIDTH);
  localparam int MEM_AW     = $clog2(MEM_WORDS);
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  imem_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_in_data;
  logic                  r_ready;
  logic                  r_busy;

  logic                  w_load_we;
  logic [MEM_AW-1:0]     w_waddr;
  logic [MEM_AW-1:0]     w_rbase;
  logic [LINE_WIDTH-1:0] w_rd_line;
  logic [LINE_WIDTH-1:0] w_resp_line;

  assign w_waddr = load_addr[MEM_AW+1:2];
  assign w_rbase = r_addr[MEM_AW+1:2];

`ifdef IMEM_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * 4);

  logic w_req_oor;
  logic w_load_oor;
  logic r_resp_err;

  assign w_req_oor   = {1'b0, r_addr}    >= MEM_BYTES;
  assign w_load_oor  = {1'b0, load_addr} >= MEM_BYTES;
  assign w_load_we   = load_en & ~w_load_oor;
  assign w_resp_line = w_req_oor ? '0 : w_rd_line;
  assign resp_err    = r_resp_err;
`else
  assign w_load_we   = load_en;
  assign w_resp_line = w_rd_line;
`endif

  imem_line_responder_word_array #(
    .MEM_WORDS  (MEM_WORDS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_load_we),
    .i_waddr (w_waddr),
    .i_wdata (load_data),
    .i_rbase (w_rbase),
    .o_line  (w_rd_line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IMEM_S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_in_data <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
      r_resp_err <= 1'b0;
`endif
    end else begin
      // NOTE: default-low here makes the ready pulse exactly one cycle without a separate clear state.
      r_ready <= 1'b0;
      case (r_state)
        IMEM_S_IDLE: begin
          if (req_to_mem) begin
            r_addr  <= {req_to_mem_addr[ADDR_WIDTH-1:LOFF], LOFF'(0)};
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= (LATENCY == 1) ? IMEM_S_RESP : IMEM_S_WAIT;
          end
        end
        IMEM_S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= IMEM_S_RESP;
        end
        IMEM_S_RESP: begin
          r_in_data <= w_resp_line;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
          r_resp_err <= w_req_oor;
`endif
          r_state   <= IMEM_S_DONE;
        end
        IMEM_S_DONE: r_state <= IMEM_S_IDLE;
        default:     r_state <= IMEM_S_IDLE;
      endcase
    end
  end

  assign in_data       = r_in_data;
  assign in_data_ready = r_ready;
  assign busy          = r_busy;

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: a LATENCY=5 instance and a LATENCY=1 instance
// sharing clock, reset and the load port.
module tb_imem_line_responder;

  localparam logic [127:0] LINE50   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE50_M = 128'h44444444_DEADBEEF_22222222_11111111;
  localparam logic [127:0] LINE50_R = 128'h44444444_DEADBEEF_CAFEF00D_11111111;
  localparam logic [127:0] LINE60   = 128'hF0F0F0F0_0F0F0F0F_89ABCDEF_01234567;
  localparam logic [127:0] LINE0    = 128'hD0E0F000_90A0B0C0_50607080_10203040;
  localparam logic [127:0] LINE0_W  = 128'hD0E0F000_77777777_50607080_10203040;

  logic         clk;
  logic         reset;
  logic         req, req1;
  logic [31:0]  addr, addr1;
  logic [127:0] in_data, in_data1;
  logic         rdy, rdy1;
  logic         busy, busy1;
  logic         load_en;
  logic [31:0]  load_addr;
  logic [31:0]  load_data;
`ifdef IMEM_ADDR_CHECK_EN
  logic         resp_err, resp_err1;
`endif

  int total = 0;
  int bad   = 0;

  imem_line_responder #(.LATENCY(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_to_mem      (req),
    .req_to_mem_addr (addr),
    .in_data         (in_data),
    .in_data_ready   (rdy),
    .busy            (busy),
`ifdef IMEM_ADDR_CHECK_EN
    .resp_err        (resp_err),
`endif
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data)
  );

  imem_line_responder #(.LATENCY(1)) dut1 (
    .clk             (clk),
    .reset           (reset),
    .req_to_mem      (req1),
    .req_to_mem_addr (addr1),
    .in_data         (in_data1),
    .in_data_ready   (rdy1),
    .busy            (busy1),
`ifdef IMEM_ADDR_CHECK_EN
    .resp_err        (resp_err1),
`endif
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  // One request on the LATENCY=5 instance; the ready pulse is expected 5 edges after acceptance.
  task automatic do_req(input string tag, input logic [31:0] a, input logic [127:0] exp_line);
    int pulses = 0;
    req  = 1'b1;
    addr = a;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rdy) pulses++;
      if (i == 5) begin
        check({tag, "_rdy"}, rdy, 1'b1);
        check({tag, "_data"}, in_data, exp_line);
        req = 1'b0;
      end
    end
    check({tag, "_pulses"}, pulses, 1);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; req = 1'b0; addr = '0; req1 = 1'b0; addr1 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    step();
    step();
    check("rst_data", in_data, '0);
    check("rst_rdy", rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    load_word(32'h50, 32'h11111111);
    load_word(32'h54, 32'h22222222);
    load_word(32'h58, 32'h33333333);
    load_word(32'h5C, 32'h44444444);
    load_word(32'h60, 32'h01234567);
    load_word(32'h64, 32'h89ABCDEF);
    load_word(32'h68, 32'h0F0F0F0F);
    load_word(32'h6C, 32'hF0F0F0F0);

    // Unaligned request, held through DONE, then a second request LATENCY+2 later.
    req = 1'b1; addr = 32'h52;
    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("t12_rdy_%0d", i), rdy, (i == 5 || i == 12));
      if (i == 0) check("t1_busy", busy, 1'b1);
      if (i == 5) begin
        check("t1_data", in_data, LINE50);
        check("t1_busy_clr", busy, 1'b0);
        addr = 32'h60;
      end
      if (i == 6) begin
        check("t2_idle_busy", busy, 1'b0);
        check("t1_hold", in_data, LINE50);
      end
      if (i == 7) check("t2_busy", busy, 1'b1);
      if (i == 12) begin
        check("t2_data", in_data, LINE60);
        req = 1'b0;
      end
    end

    // Loads during WAIT and in the RESP cycle; the request address changes mid-WAIT.
    req = 1'b1; addr = 32'h50;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t3_rdy_%0d", i), rdy, (i == 5));
      if (i == 1) begin
        load_en = 1'b1; load_addr = 32'h58; load_data = 32'hDEADBEEF;
        addr = 32'h100;
      end
      if (i == 2) load_en = 1'b0;
      if (i == 4) begin
        load_en = 1'b1; load_addr = 32'h54; load_data = 32'hCAFEF00D;
      end
      if (i == 5) begin
        load_en = 1'b0;
        check("t3_data", in_data, LINE50_R);
        req = 1'b0;
      end
    end

    // Reset two cycles into WAIT aborts the response.
    req = 1'b1; addr = 32'h50;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 1'b0;
    check("t4_busy", busy, 1'b0);
    check("t4_data", in_data, '0);
    check("t4_rdy", rdy, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rdy) pulses++;
    end
    check("t4_no_pulse", pulses, 0);
    do_req("t4_after", 32'h50, LINE50_R);

    // LATENCY=1 instance: ready one edge after acceptance.
    req1 = 1'b1; addr1 = 32'h60;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5_l1_rdy_%0d", i), rdy1, (i == 1));
      if (i == 1) begin
        check("t5_l1_data", in_data1, LINE60);
        req1 = 1'b0;
      end
    end

    // Request dropped during WAIT still completes.
    req = 1'b1; addr = 32'h60;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) req = 1'b0;
      if (rdy) pulses++;
      if (i == 5) check("t5_drop_data", in_data, LINE60);
    end
    check("t5_drop_pulses", pulses, 1);

    // High addresses: wrap in the default build, rejected with the address check.
    load_word(32'h00, 32'h10203040);
    load_word(32'h04, 32'h50607080);
    load_word(32'h08, 32'h90A0B0C0);
    load_word(32'h0C, 32'hD0E0F000);
    load_word(32'h4008, 32'h77777777);
`ifdef IMEM_ADDR_CHECK_EN
    do_req("t6_oor", 32'hF0000000, '0);
    check("t6_oor_err", resp_err, 1'b1);
    do_req("t6_line0", 32'h0, LINE0);
    check("t6_line0_err", resp_err, 1'b0);
`else
    do_req("t6_wrap", 32'hF0000000, LINE0_W);
    do_req("t6_line0", 32'h0, LINE0_W);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
